// File: rtl/spi_pkg.sv
// Shared types, defaults and helpers for the SPI master core and its clock generator.
package spi_pkg;

    localparam int SPI_DATA_W = 32;
    localparam int SPI_NUM_SS = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } spi_state_t;

    // SCLK half-period length in clk cycles for each divider select value.
    function automatic logic [3:0] scks_to_half(input logic [1:0] scks);
        logic [3:0] half;
        case (scks)
            2'b00:   half = 4'd1;
            2'b01:   half = 4'd2;
            2'b10:   half = 4'd4;
            default: half = 4'd8;
        endcase
        return half;
    endfunction

    // Number of SCLK toggles in one frame: a leading and a trailing edge per bit.
    function automatic int edge_count(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: pulses tick for one cycle every H clk cycles while enabled.
module spi_clk_gen
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] scks,
    output logic       tick
);

    logic [3:0] cnt;
    logic [3:0] half;

    assign half = scks_to_half(scks);
    assign tick = en && (cnt == (half - 4'd1));

    // Count cycles within the current half-period; restart on every tick and hold at zero while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 4'd0;
        end else if (!en || tick) begin
            cnt <= 4'd0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// SPI master shift engine: one fixed-length frame per start_op rising edge.
module spi_master_core
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int NUM_SS = SPI_NUM_SS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              ctrl_cpol,
    input  logic              ctrl_cpha,
    input  logic              ctrl_order,
    input  logic [NUM_SS-1:0] ctrl_slave_en,
    input  logic              ctrl_rd,
    input  logic [1:0]        ctrl_scks,
    input  logic              start_op,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int EDGES = edge_count(DATA_W);
    localparam int ECW   = $clog2(EDGES);

    spi_state_t        state;
    spi_state_t        state_next;
    logic              start_d;
    logic              launch;
    logic              tick;
    logic              leading;
    logic              last_edge;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [ECW-1:0]    edge_cnt;
    logic              cpha_q;
    logic              order_q;
    logic              rd_q;
    logic              sclk_q;
    logic [NUM_SS-1:0] slave_en_q;
    logic [1:0]        scks_q;

    // LSB-first frames are stored reversed so the shifter always works from the top bit.
    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

    assign launch    = (state == IDLE) && start_op && !start_d;
    assign leading   = ~edge_cnt[0];
    assign last_edge = (edge_cnt == ECW'(EDGES - 1));

    assign busy = (state != IDLE);
    assign sclk = sclk_q;
    assign mosi = busy ? tx_sh[DATA_W-1] : 1'b0;
    assign ss_n = busy ? ~slave_en_q : '1;

    spi_clk_gen u_clk_gen (
        .clk   (clk),
        .reset (reset),
        .en    (busy),
        .scks  (scks_q),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase sequencing: every phase boundary falls on a half-period tick.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch)             state_next = SETUP;
            SETUP:   if (tick)               state_next = SHIFT;
            SHIFT:   if (tick && last_edge)  state_next = HOLD;
            HOLD:    if (tick)               state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // Start edge detect, configuration snapshot, SCLK generation, shifting and rx_data update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_d    <= 1'b0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            edge_cnt   <= '0;
            cpha_q     <= 1'b0;
            order_q    <= 1'b0;
            rd_q       <= 1'b0;
            sclk_q     <= 1'b0;
            slave_en_q <= '0;
            scks_q     <= 2'b00;
            rx_data    <= '0;
        end else begin
            start_d <= start_op;
            case (state)
                IDLE: begin
                    sclk_q   <= ctrl_cpol;
                    edge_cnt <= '0;
                    if (launch) begin
                        tx_sh      <= ctrl_order ? bit_rev(tx_data) : tx_data;
                        rx_sh      <= '0;
                        cpha_q     <= ctrl_cpha;
                        order_q    <= ctrl_order;
                        rd_q       <= ctrl_rd;
                        slave_en_q <= ctrl_slave_en;
                        scks_q     <= ctrl_scks;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sclk_q   <= ~sclk_q;
                        edge_cnt <= edge_cnt + ECW'(1);
                        if (leading == !cpha_q) begin
                            rx_sh <= {rx_sh[DATA_W-2:0], miso};
                        end else if (cpha_q ? (edge_cnt != '0) : !last_edge) begin
                            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (tick && rd_q) begin
                        rx_data <= order_q ? bit_rev(rx_sh) : rx_sh;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Randomised scoreboard bench for spi_master_core with a frame-level reference model.
module tb_spi_master_core;

    typedef struct {
        logic [31:0] tx;
        logic        cpol;
        logic        cpha;
        logic        order;
        logic [3:0]  sen;
        logic        rd;
        logic [1:0]  scks;
        int          mode;   // 0 miso=mosi, 1 miso=~mosi, 2 miso=1, 3 miso=0
    } cfg_t;

    typedef struct {
        cfg_t        c;
        int          h;
        logic [31:0] rx;
        logic [31:0] stream;  // bits in wire order, first bit at [31]
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] tx_data;
    logic        ctrl_cpol, ctrl_cpha, ctrl_order, ctrl_rd;
    logic [3:0]  ctrl_slave_en;
    logic [1:0]  ctrl_scks;
    logic        start_op;
    logic [31:0] rx_data;
    logic        busy, sclk, mosi, miso;
    logic [3:0]  ss_n;

    int          miso_mode;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          aborting = 1'b0;
    logic [31:0] rx_model = '0;
    exp_t        sb[$];

    exp_t        cur;
    bit          have_cur = 1'b0;
    int          busy_cnt, edges, nbits, ss_err;
    logic [31:0] stream_obs;
    logic        prev_busy = 1'b0;
    logic        prev_sclk = 1'b0;
    logic        lead_edge;

    always #5 clk = ~clk;

    assign miso = (miso_mode == 0) ? mosi :
                  (miso_mode == 1) ? ~mosi :
                  (miso_mode == 2);

    spi_master_core dut (
        .clk           (clk),
        .reset         (reset),
        .tx_data       (tx_data),
        .ctrl_cpol     (ctrl_cpol),
        .ctrl_cpha     (ctrl_cpha),
        .ctrl_order    (ctrl_order),
        .ctrl_slave_en (ctrl_slave_en),
        .ctrl_rd       (ctrl_rd),
        .ctrl_scks     (ctrl_scks),
        .start_op      (start_op),
        .rx_data       (rx_data),
        .busy          (busy),
        .sclk          (sclk),
        .mosi          (mosi),
        .miso          (miso),
        .ss_n          (ss_n)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int halfOf(input logic [1:0] s);
        return 1 << s;
    endfunction

    // With loopback, whatever order bits leave in they return in, so the captured word equals tx.
    function automatic logic [31:0] misoWord(input cfg_t c);
        case (c.mode)
            0:       return c.tx;
            1:       return ~c.tx;
            2:       return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic cfg_t mkCfg(input logic [31:0] tx, input logic cpol, input logic cpha,
                                   input logic order, input logic [3:0] sen, input logic rd,
                                   input logic [1:0] scks, input int mode);
        cfg_t c;
        c.tx = tx; c.cpol = cpol; c.cpha = cpha; c.order = order;
        c.sen = sen; c.rd = rd; c.scks = scks; c.mode = mode;
        return c;
    endfunction

    function automatic cfg_t randCfg();
        return mkCfg($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
    endfunction

    // Drive one configuration with a start edge and record what the frame must look like.
    task automatic applyStimulus(input cfg_t c);
        exp_t e;
        tx_data = c.tx; ctrl_cpol = c.cpol; ctrl_cpha = c.cpha; ctrl_order = c.order;
        ctrl_slave_en = c.sen; ctrl_rd = c.rd; ctrl_scks = c.scks; miso_mode = c.mode;
        start_op = 1'b1;
        e.c = c;
        e.h = halfOf(c.scks);
        e.rx = c.rd ? misoWord(c) : rx_model;
        for (int k = 0; k < 32; k++) begin
            e.stream[31-k] = c.order ? c.tx[k] : c.tx[31-k];
        end
        rx_model = e.rx;
        sb.push_back(e);
    endtask

    task automatic waitBusy(input logic level, input int limit, input string name);
        int n = 0;
        while (busy !== level && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== level) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: busy timeout after %0d cycles, required busy=%0d", name, n, level);
        end
    endtask

    task automatic runFrame(input cfg_t c, input bit keep_start);
        @(posedge clk); #1;
        applyStimulus(c);
        waitBusy(1'b1, 4, "launch");
        if (!keep_start) start_op = 1'b0;
        waitBusy(1'b0, 66 * 8 + 8, "frame_end");
    endtask

    // Monitor: observes each frame on the pins and compares it with the oldest expectation.
    always @(negedge clk) begin
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
            checkOutput("launch_expected", sb.size() != 0, 1);
            have_cur = (sb.size() != 0);
            busy_cnt = 0; edges = 0; nbits = 0; ss_err = 0; stream_obs = '0;
            if (have_cur) begin
                cur = sb[0];
                checkOutput("setup_sclk_idle", sclk, cur.c.cpol);
                checkOutput("setup_mosi_bit0", mosi, cur.stream[31]);
                checkOutput("setup_ss_n", ss_n, 4'(~cur.c.sen));
            end
        end
        if (busy === 1'b1 && have_cur) begin
            busy_cnt++;
            if (ss_n !== ~cur.c.sen) ss_err++;
            if (busy_cnt > 1 && sclk !== prev_sclk) begin
                edges++;
                lead_edge = (sclk !== cur.c.cpol);
                if (lead_edge != cur.c.cpha) begin
                    stream_obs = {stream_obs[30:0], mosi};
                    nbits++;
                end
            end
        end
        if (busy !== 1'b1 && prev_busy === 1'b1) begin
            if (aborting) begin
                if (sb.size() != 0) void'(sb.pop_front());
            end else if (have_cur) begin
                void'(sb.pop_front());
                checkOutput("rx_data", rx_data, cur.rx);
                checkOutput("busy_cycles", busy_cnt, 66 * cur.h);
                checkOutput("sclk_edges", edges, 64);
                checkOutput("mosi_bits", nbits, 32);
                checkOutput("mosi_stream", stream_obs, cur.stream);
                checkOutput("ss_n_during_busy", ss_err, 0);
                checkOutput("end_sclk_idle", prev_sclk, cur.c.cpol);
                checkOutput("end_mosi_zero", mosi, 0);
                checkOutput("end_ss_n", ss_n, 4'hF);
            end
            have_cur = 1'b0;
        end
        prev_busy = busy;
        prev_sclk = sclk;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomised frames.
    initial begin
        int seen;
        reset = 1'b0; start_op = 1'b0; tx_data = '0; ctrl_cpol = 1'b0; ctrl_cpha = 1'b0;
        ctrl_order = 1'b0; ctrl_slave_en = '0; ctrl_rd = 1'b0; ctrl_scks = 2'b00; miso_mode = 0;
        #12;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rx_data", rx_data, 0);
        checkOutput("reset_sclk", sclk, 0);
        checkOutput("reset_mosi", mosi, 0);
        checkOutput("reset_ss_n", ss_n, 4'hF);
        @(posedge clk); #3 reset = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] mode 0, MSB first, loopback");
        runFrame(mkCfg(32'hA5A5_0F0F, 0, 0, 0, 4'b0001, 1, 2'b00, 0), 1'b0);
        checkOutput("t1_rx", rx_data, 32'hA5A5_0F0F);

        $display("[TB] mode 3, LSB first, miso high");
        runFrame(mkCfg(32'h0000_0001, 1, 1, 1, 4'b0100, 1, 2'b10, 2), 1'b0);
        checkOutput("t2_rx", rx_data, 32'hFFFF_FFFF);

        $display("[TB] rd=0 keeps rx_data");
        runFrame(mkCfg(32'h1234_5678, 0, 1, 0, 4'b0010, 1, 2'b01, 0), 1'b0);
        runFrame(mkCfg($urandom, 1, 0, 1, 4'b1000, 0, 2'b00, 2), 1'b0);
        checkOutput("t3_rx_hold", rx_data, 32'h1234_5678);

        $display("[TB] reset during bit 10");
        @(posedge clk); #1;
        applyStimulus(mkCfg($urandom, 1, 0, 0, 4'b1010, 1, 2'b01, 0));
        waitBusy(1'b1, 4, "t5_launch");
        start_op = 1'b0;
        repeat (44) @(posedge clk);
        #2 aborting = 1'b1; reset = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ss_n", ss_n, 4'hF);
        checkOutput("abort_sclk", sclk, 0);
        checkOutput("abort_mosi", mosi, 0);
        checkOutput("abort_rx_data", rx_data, 0);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b1; aborting = 1'b0; rx_model = '0;
        seen = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (busy) seen++;
        end
        checkOutput("t5_quiet_after_reset", seen, 0);

        $display("[TB] start toggles and config changes mid-frame");
        @(posedge clk); #1;
        applyStimulus(mkCfg($urandom, 0, 1, 1, 4'b0110, 1, 2'b01, 0));
        waitBusy(1'b1, 4, "t4_launch");
        repeat (20) @(posedge clk);
        #1 start_op = 1'b0; tx_data = $urandom; ctrl_cpol = 1'b1; ctrl_cpha = 1'b0;
        ctrl_order = 1'b0; ctrl_slave_en = 4'b1001; ctrl_rd = 1'b0; ctrl_scks = 2'b11;
        repeat (5) @(posedge clk);
        #1 start_op = 1'b1;
        repeat (5) @(posedge clk);
        #1 start_op = 1'b0;
        repeat (5) @(posedge clk);
        #1 start_op = 1'b1;
        waitBusy(1'b0, 66 * 8 + 8, "t4_end");
        seen = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (busy) seen++;
        end
        checkOutput("t4_no_relaunch", seen, 0);
        start_op = 1'b0;

        $display("[TB] back-to-back launch");
        runFrame(mkCfg($urandom, 0, 0, 0, 4'b0011, 1, 2'b00, 1), 1'b0);
        applyStimulus(mkCfg($urandom, 1, 1, 0, 4'b1100, 1, 2'b00, 0));
        @(posedge clk); #1;
        checkOutput("b2b_busy_rise", busy, 1);
        start_op = 1'b0;
        waitBusy(1'b0, 66 * 8 + 8, "b2b_end");

        $display("[TB] random frames");
        for (int i = 0; i < 10; i++) begin
            runFrame(randCfg(), 1'b0);
        end

        repeat (5) @(posedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
